// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs, ALU codes.
// BNEBR exists only when BNE_EN is defined.
package mips_ctrl_pkg;

    localparam int ST_BITS = 4;

    typedef enum logic [ST_BITS-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
`ifdef BNE_EN
        , BNEBR = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp and the instruction Funct to an ALU code,
// flagging any Funct the datapath does not implement.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic [ALUC_W-1:0] alu_control,
    output logic              funct_illegal
);

    always_comb begin
        alu_control   = ALUC_W'(ALU_ADD);
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALUC_W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_W'(ALU_ADD);
                    FN_SUB:  alu_control = ALUC_W'(ALU_SUB);
                    FN_AND:  alu_control = ALUC_W'(ALU_AND);
                    FN_OR:   alu_control = ALUC_W'(ALU_OR);
                    FN_SLT:  alu_control = ALUC_W'(ALU_SLT);
                    FN_SLL:  alu_control = ALUC_W'(ALU_SLL);
                    // Unknown funct still executes as an add so the instruction completes.
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALUC_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing a multi-cycle MIPS datapath; outputs decode the state register.
// Optional macro BNE_EN adds the BNEBR state for bne (opcode 000101).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUC_W = 4,
    parameter int ST_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Op,
    input  logic [5:0]        Funct,
    input  logic              Zero,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              PCEn,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        PCSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              illegal,
    output logic [ST_W-1:0]   state_dbg
);

    state_t            state;
    logic [1:0]        alu_op;
    logic [ALUC_W-1:0] alu_ctrl;
    logic              funct_illegal;
    logic              pc_write;
    logic              branch;
    logic              branch_ne;

    mips_alu_decoder #(.ALUC_W(ALUC_W)) u_alu_dec (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (alu_ctrl),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
`ifdef BNE_EN
                        OP_BNE:       state <= BNEBR;
`endif
                        default: begin
                            state   <= FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                MEMADR:  state <= (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state <= MEMWB;
                EXECUTE: begin
                    if (funct_illegal)
                        illegal <= 1'b1;
                    state <= ALUWB;
                end
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        PCSrc     = PCSRC_ALU;
        alu_op    = ALUOP_ADD;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        case (state)
            FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
            end
            DECODE:  ALUSrcB = SRCB_IMM_SH;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                PCSrc   = PCSRC_ALUOUT;
            end
`ifdef BNE_EN
            BNEBR: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                branch_ne = 1'b1;
                PCSrc     = PCSRC_ALUOUT;
            end
`endif
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        PCEn = pc_write | (branch & Zero) | (branch_ne & ~Zero);
        // Reset overrides the state decode so nothing is written while it is held.
        if (reset) begin
            IorD     = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCEn     = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            PCSrc    = 2'b00;
        end
    end

    assign ALUControl = reset ? '0 : alu_ctrl;
    assign state_dbg  = ST_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed steps plus random instruction mix against a
// per-instruction cycle model; honours BNE_EN like the design.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [3:0] aluc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl;
    logic       illegal;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    bit ill_model = 1'b0;

    mips_multicycle_ctrl #(.ALUC_W(4), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic bit bne_supported();
`ifdef BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            6'b000101: return bne_supported();
            default:   return 1'b0;
        endcase
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            6'b000101: return bne_supported() ? 3 : 2;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [3:0] funct_code(input logic [5:0] fn, output bit known);
        known = 1'b1;
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b000000: return 4'b1000;
            default: begin
                known = 1'b0;
                return 4'b0010;
            end
        endcase
    endfunction

    // Expected outputs for cycle k (0-based) of one instruction.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int k);
        exp_t e;
        bit   kn;
        e      = '0;
        e.aluc = 4'b0010;
        if (k == 0) begin
            e.st = 4'(FETCH); e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1;
        end else if (k == 1) begin
            e.st = 4'(DECODE); e.alusrcb = 2'b11;
        end else begin
            case (op)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin
                        e.st = 4'(MEMADR); e.alusrca = 1; e.alusrcb = 2'b10;
                    end else if (op == 6'b101011) begin
                        e.st = 4'(MEMWR); e.iord = 1; e.memwrite = 1;
                    end else if (k == 3) begin
                        e.st = 4'(MEMRD); e.iord = 1;
                    end else begin
                        e.st = 4'(MEMWB); e.memtoreg = 1; e.regwrite = 1;
                    end
                end
                6'b000000: begin
                    if (k == 2) begin
                        e.st = 4'(EXECUTE); e.alusrca = 1; e.aluc = funct_code(fn, kn);
                    end else begin
                        e.st = 4'(ALUWB); e.regdst = 1; e.regwrite = 1;
                    end
                end
                6'b000100: begin
                    e.st = 4'(BRANCH); e.alusrca = 1; e.aluc = 4'b0110;
                    e.pcsrc = 2'b01; e.pcen = z;
                end
`ifdef BNE_EN
                6'b000101: begin
                    e.st = 4'(BNEBR); e.alusrca = 1; e.aluc = 4'b0110;
                    e.pcsrc = 2'b01; e.pcen = ~z;
                end
`endif
                6'b001000: begin
                    if (k == 2) begin
                        e.st = 4'(ADDIEX); e.alusrca = 1; e.alusrcb = 2'b10;
                    end else begin
                        e.st = 4'(ADDIWB); e.regwrite = 1;
                    end
                end
                default: begin
                    e.st = 4'(JUMP); e.pcsrc = 2'b10; e.pcen = 1;
                end
            endcase
        end
        return e;
    endfunction

    task automatic check_vec(input string tag, input exp_t e);
        exp_t o;
        o = {state_dbg, IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, ALUControl};
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
        n_cmp++;
        assert (illegal === ill_model) else begin
            n_bad++;
            $error("FAIL %s.illegal: observed=%b expected=%b", tag, illegal, ill_model);
        end
    endtask

    task automatic check_reset_state(input string tag);
        exp_t e;
        e    = '0;
        e.st = 4'(FETCH);
        check_vec(tag, e);
    endtask

    // Assert reset mid-cycle, hold it across an edge, then release just after an edge.
    task automatic apply_reset(input string tag);
        #2 reset = 1'b1;
        ill_model = 1'b0;
        #1 check_reset_state({tag, ".async"});
        @(posedge clk);
        #1 check_reset_state({tag, ".held"});
        #2 reset = 1'b0;
    endtask

    // zmode: 0/1 force Zero, 2 random. abort_at >= 0 pulses reset during that cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int abort_at);
        int   n;
        exp_t e;
        bit   kn;
        logic [3:0] dummy;
        n = cpi(op);
        for (int k = 0; k < n; k++) begin
            Op    = op;
            Funct = fn;
            Zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            e = model(op, fn, Zero, k);
            check_vec($sformatf("%s.c%0d", tag, k), e);
            if (k == abort_at) begin
                apply_reset({tag, ".abort"});
                return;
            end
            if (k == 1 && !op_known(op)) ill_model = 1'b1;
            dummy = funct_code(fn, kn);
            if (k == 2 && op == 6'b000000 && !kn) ill_model = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [6];
        logic [5:0] rop, rfn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        reset = 1'b1;
        Op    = 6'b0;
        Funct = 6'b0;
        Zero  = 1'b0;
        @(posedge clk);
        #1 check_reset_state("por");
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr("lw",       6'b100011, 6'b000000, 2, -1);
        run_instr("sw",       6'b101011, 6'b000000, 2, -1);
        run_instr("beq_z1",   6'b000100, 6'b000000, 1, -1);
        run_instr("beq_z0",   6'b000100, 6'b000000, 0, -1);
        run_instr("r_slt",    6'b000000, 6'b101010, 2, -1);
        run_instr("r_sub",    6'b000000, 6'b100010, 2, -1);
        run_instr("r_badfn",  6'b000000, 6'b111111, 2, -1);
        run_instr("r_add",    6'b000000, 6'b100000, 2, -1);
        apply_reset("clr");
        run_instr("bad_op",   6'b111111, 6'b000000, 2, -1);
        run_instr("lw_abort", 6'b100011, 6'b000000, 2, 3);
        run_instr("bne_z0",   6'b000101, 6'b000000, 0, -1);
        run_instr("bne_z1",   6'b000101, 6'b000000, 1, -1);
        run_instr("j",        6'b000010, 6'b000000, 2, -1);
        run_instr("addi",     6'b001000, 6'b000000, 2, -1);
        run_instr("r_sll",    6'b000000, 6'b000000, 2, -1);
        apply_reset("clr2");

        for (int i = 0; i < 300; i++) begin
            int oi, fi;
            oi  = int'($urandom_range(0, 7));
            fi  = int'($urandom_range(0, 6));
            rop = (oi == 7) ? 6'($urandom_range(0, 63)) : ops[oi];
            rfn = (fi == 6) ? 6'($urandom_range(0, 63)) : fns[fi];
            run_instr($sformatf("rnd%0d", i), rop, rfn, 2, -1);
            if ($urandom_range(0, 39) == 0) apply_reset($sformatf("rnd_rst%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
